// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides; shifts run one bit per cycle.
// Optional build macro ALU_SAT_EN: ADD/SUB saturate to signed max/min on overflow.
module alu_nbit_seq #(
  parameter int WIDTH     = 8,
  parameter bit ARITH_SHR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             right_q, right_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its data until then, and out_valid/result stay put until out_ready.
  assign in_ready  = (state_q == IDLE) && (!valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_shift  = (alu_op[2:1] == 2'b11);
  assign amt       = b[SHW-1:0];

  assign out_valid = valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign busy      = (state_q == SHIFT);

  // Single-cycle datapath; shift opcodes fall through to result=a for the zero-amount case.
  always_comb begin
    sub       = (alu_op == OP_SUB);
    b_eff     = sub ? (~b + WIDTH'(1)) : b;
    sum       = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
    alu_res   = a;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = ~sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      default: alu_res = a;
    endcase
`ifdef ALU_SAT_EN
    // Flags keep reporting the raw overflow; only the result is clamped.
    if (alu_ovf) begin
      alu_res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    step_bit = right_q ? sh_q[0] : sh_q[WIDTH-1];
    step_val = right_q ? {(ARITH_SHR ? sh_q[WIDTH-1] : 1'b0), sh_q[WIDTH-1:1]}
                       : {sh_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    right_d  = right_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    valid_d  = valid_q && !out_ready;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (amt != '0)) begin
            state_d = SHIFT;
            sh_d    = a;
            cnt_d   = amt;
            right_d = alu_op[0];
          end else begin
            result_d = alu_res;
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        sh_d  = step_val;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d  = IDLE;
          result_d = step_val;
          carry_d  = step_bit;
          ovf_d    = 1'b0;
          zero_d   = (step_val == '0);
          valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      right_q  <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      right_q  <= right_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Bench for alu_nbit_seq (WIDTH=8): directed vector table, handshake/reset sequences, random ops.
module tb_alu_nbit_seq;

  localparam int W     = 8;
  localparam bit ARITH = 1'b0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         exp;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [W+2:0] exp_q[$];

  alu_nbit_seq #(.WIDTH(W), .ARITH_SHR(ARITH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int to_s(input logic [W-1:0] x);
    return x[W-1] ? int'(x) - (1 << W) : int'(x);
  endfunction

  // Reference model: plain integer arithmetic on the opcode's meaning.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] ta, input logic [W-1:0] tb_);
    exp_t e;
    int ua, ub, s, n, bp;
    ua = int'(ta);
    ub = int'(tb_);
    n  = ub % W;
    e  = '0;
    case (op)
      3'd0: begin
        s     = ua + ub;
        e.res = W'(s);
        e.c   = (s >= (1 << W));
        s     = to_s(ta) + to_s(tb_);
        e.v   = (s > 127) || (s < -128);
      end
      3'd1: begin
        e.res = W'(ua - ub);
        e.c   = (ua < ub);
        bp    = ((1 << W) - ub) % (1 << W);
        s     = to_s(ta) + to_s(W'(bp));
        e.v   = (s > 127) || (s < -128);
      end
      3'd2: e.res = ta & tb_;
      3'd3: e.res = ta | tb_;
      3'd4: e.res = ta ^ tb_;
      3'd5: e.res = ~(ta | tb_);
      3'd6: begin
        e.res = W'(ua << n);
        e.c   = (n == 0) ? 1'b0 : 1'((ua >> (W - n)) & 1);
      end
      default: begin
        e.res = ARITH ? W'(to_s(ta) >>> n) : W'(ua >> n);
        e.c   = (n == 0) ? 1'b0 : 1'((ua >> (n - 1)) & 1);
      end
    endcase
`ifdef ALU_SAT_EN
    if (e.v) e.res = ta[W-1] ? 8'h80 : 8'h7F;
`endif
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] tb_);
    return (op >= 3'd6) ? (int'(tb_) % W) + 1 : 1;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        output exp_t got, output int lat);
    int guard;
    @(negedge clk);
    alu_op   = op;
    a        = ta;
    b        = tb_;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    chk("out_valid_arrives", out_valid, 1);
    got = {result, carry_out, overflow, zero};
  endtask

  task automatic check_vec(input string name, input exp_t got, input exp_t exp,
                           input int lat, input int exp_lat);
    chk({name, ".result"}, got.res, exp.res);
    chk({name, ".carry"}, got.c, exp.c);
    chk({name, ".overflow"}, got.v, exp.v);
    chk({name, ".zero"}, got.z, exp.z);
    chk({name, ".latency"}, lat, exp_lat);
  endtask

  vec_t vecs[14];
  exp_t got, e;
  int   lat;

  initial begin
    // Directed table, expectations written out by hand.
    vecs[0]  = '{3'd0, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b0, 1'b1}, 1};
    vecs[1]  = '{3'd1, 8'h05, 8'h03, '{8'h02, 1'b0, 1'b0, 1'b0}, 1};
    vecs[2]  = '{3'd1, 8'h03, 8'h05, '{8'hFE, 1'b1, 1'b0, 1'b0}, 1};
`ifdef ALU_SAT_EN
    vecs[3]  = '{3'd0, 8'h7F, 8'h01, '{8'h7F, 1'b0, 1'b1, 1'b0}, 1};
    vecs[12] = '{3'd1, 8'h80, 8'h01, '{8'h80, 1'b0, 1'b1, 1'b0}, 1};
    vecs[13] = '{3'd0, 8'h80, 8'h80, '{8'h80, 1'b1, 1'b1, 1'b0}, 1};
`else
    vecs[3]  = '{3'd0, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b1, 1'b0}, 1};
    vecs[12] = '{3'd1, 8'h80, 8'h01, '{8'h7F, 1'b0, 1'b1, 1'b0}, 1};
    vecs[13] = '{3'd0, 8'h80, 8'h80, '{8'h00, 1'b1, 1'b1, 1'b1}, 1};
`endif
    vecs[4]  = '{3'd6, 8'h81, 8'h03, '{8'h08, 1'b0, 1'b0, 1'b0}, 4};
    vecs[5]  = '{3'd7, 8'h80, 8'h07, '{(ARITH ? 8'hFF : 8'h01), 1'b0, 1'b0, 1'b0}, 8};
    vecs[6]  = '{3'd4, 8'h0C, 8'h0A, '{8'h06, 1'b0, 1'b0, 1'b0}, 1};
    vecs[7]  = '{3'd2, 8'hF0, 8'h3C, '{8'h30, 1'b0, 1'b0, 1'b0}, 1};
    vecs[8]  = '{3'd3, 8'h50, 8'h0A, '{8'h5A, 1'b0, 1'b0, 1'b0}, 1};
    vecs[9]  = '{3'd5, 8'h0F, 8'hF0, '{8'h00, 1'b0, 1'b0, 1'b1}, 1};
    vecs[10] = '{3'd6, 8'h5A, 8'h00, '{8'h5A, 1'b0, 1'b0, 1'b0}, 1};
    vecs[11] = '{3'd7, 8'h01, 8'h01, '{8'h00, 1'b1, 1'b0, 1'b1}, 2};

    // Clock/reset block
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; alu_op = '0;
    #12;
    chk("reset.out_valid", out_valid, 0);
    chk("reset.busy", busy, 0);
    chk("reset.result", result, 0);
    chk("reset.flags", {carry_out, overflow, zero}, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("reset.in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, got, lat);
      check_vec($sformatf("vec%0d", i), got, vecs[i].exp, lat, vecs[i].lat);
    end

    // SHL 81<<3: busy and in_ready=0 for three cycles, then result.
    @(negedge clk);
    alu_op = 3'd6; a = 8'h81; b = 8'h03; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("shl_busy%0d", i), busy, 1);
      chk($sformatf("shl_in_ready%0d", i), in_ready, 0);
      chk($sformatf("shl_out_valid%0d", i), out_valid, 0);
    end
    @(negedge clk);
    chk("shl_done.busy", busy, 0);
    chk("shl_done.out_valid", out_valid, 1);
    chk("shl_done.result", result, 8'h08);
    chk("shl_done.carry", carry_out, 0);

    // Backpressure: XOR result held while a competing op is presented.
    @(negedge clk);
    out_ready = 1'b0;
    alu_op = 3'd4; a = 8'h0C; b = 8'h0A; in_valid = 1'b1;
    @(posedge clk);
    #1 alu_op = 3'd0; a = 8'h01; b = 8'h02;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_result%0d", i), result, 8'h06);
      chk($sformatf("bp_in_ready%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release.in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next.out_valid", out_valid, 1);
    chk("bp_next.result", result, 8'h03);
    @(negedge clk);
    chk("bp_drain.out_valid", out_valid, 0);

    // Reset pulsed two cycles into SHL by 5.
    @(negedge clk);
    alu_op = 3'd6; a = 8'h5A; b = 8'h05; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid.busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.out_valid", out_valid, 0);
    @(negedge clk) rst = 1'b0;
    run_op(3'd0, 8'h01, 8'h01, got, lat);
    check_vec("rst_after_add", got, '{8'h02, 1'b0, 1'b0, 1'b0}, lat, 1);

    // Random operations against the reference model via the expected queue.
    for (int i = 0; i < 200; i++) begin
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom_range(0, 255));
      rb  = W'($urandom_range(0, 255));
      exp_q.push_back(model(rop, ra, rb));
      run_op(rop, ra, rb, got, lat);
      e = exp_q.pop_front();
      check_vec($sformatf("rand%0d op%0d a%0h b%0h", i, rop, ra, rb), got, e, lat, model_lat(rop, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
